// File: rtl/poly_stream_out.sv
// poly_stream_out
//
// Drain stage for the polynomial-ops datapath. Once an element-wise op has
// written its result polynomial into the dual-port BRAM pair, this block reads
// it back four coefficients per read cycle and streams them out on a
// valid/ready interface. A small credit-tracked FIFO absorbs backpressure.
// A BRAM read is only issued when its returning data is guaranteed a FIFO
// slot, so reads are never stalled mid-flight.
//
// Coefficient i lives in bank i%2 at address i/2. Beat b therefore reads
// address 2b (port a) and 2b+1 (port b) of banks 0 and 1 in one cycle.
//
// Ports
//   clk, reset      clock and synchronous active-high reset
//   start           begin draining one polynomial (only looked at in IDLE)
//   bram_en/we      per-bank enable / write enable (banks 0..3)
//   bram_addr_a/b   per-bank port a / port b addresses
//   bram_di_a/b     per-bank write data (always zero, this block only reads)
//   bram_do_a/b     per-bank read data, valid the cycle after en
//   m_data          beat b: [K-1:0]=4b, [2K-1:K]=4b+1, [3K-1:2K]=4b+2, [4K-1:3K]=4b+3
//   m_valid/m_ready stream handshake
//   m_last          high on the final beat (N/4-1)
//   busy            high while reading or draining
//   done            one-cycle pulse after the last beat is accepted

module poly_stream_out #(
    parameter int N          = 16,
    parameter int K          = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int NB        = N / 4,
    localparam int BW        = (NB > 1) ? $clog2(NB) : 1,
    localparam int AW        = BW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,

    output logic [3:0]            bram_en,
    output logic [3:0]            bram_we,
    output logic [3:0][AW-1:0]    bram_addr_a,
    output logic [3:0][AW-1:0]    bram_addr_b,
    output logic [3:0][K-1:0]     bram_di_a,
    output logic [3:0][K-1:0]     bram_di_b,
    input  logic [3:0][K-1:0]     bram_do_a,
    input  logic [3:0][K-1:0]     bram_do_b,

    output logic [4*K-1:0]        m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_PTR = BW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE,
        READING,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    logic [BW-1:0]       rd_ptr;
    logic                inflight;
    logic                inflight_last;

    logic [4*K-1:0]      fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [FW-1:0]       wr_idx;
    logic [FW-1:0]       rd_idx;
    logic [CW-1:0]       fifo_count;

    logic [CW:0]         credit_used;
    logic                issue;
    logic                last_issue;
    logic                push;
    logic                pop;
    logic [4*K-1:0]      push_data;
    logic                unused_bank_data;

    // Banks 2 and 3 are wired up but never read.
    assign unused_bank_data = ^{bram_do_a[3], bram_do_a[2], bram_do_b[3], bram_do_b[2]};

    // Credit rule: every slot is either occupied in the FIFO or reserved by
    // the read whose data arrives next cycle. A read is issued only when a
    // slot remains unreserved, so the push never finds the FIFO full.
    // Reset gates the enable so nothing is launched in the reset cycle.
    assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign issue       = (state == READING) && !reset && (credit_used < DEPTH_W);
    assign last_issue  = issue && (rd_ptr == LAST_PTR);

    // Read data is pushed the cycle it appears; the pop side is the stream
    // handshake itself.
    assign push      = inflight;
    assign pop       = m_valid && m_ready;
    assign push_data = {bram_do_b[1], bram_do_b[0], bram_do_a[1], bram_do_a[0]};

    assign m_valid = (fifo_count != '0);
    assign m_data  = fifo_data[rd_idx];
    assign m_last  = m_valid && fifo_last[rd_idx];

    // BRAM drive: only banks 0 and 1 carry reads; both share the same
    // address pair (even word on port a, odd word on port b).
    always_comb begin
        bram_en     = '0;
        bram_we     = '0;
        bram_addr_a = '0;
        bram_addr_b = '0;
        bram_di_a   = '0;
        bram_di_b   = '0;
        bram_en[0]     = issue;
        bram_en[1]     = issue;
        bram_addr_a[0] = {rd_ptr, 1'b0};
        bram_addr_a[1] = {rd_ptr, 1'b0};
        bram_addr_b[0] = {rd_ptr, 1'b1};
        bram_addr_b[1] = {rd_ptr, 1'b1};
    end

    // Control FSM. inflight remembers last cycle's issue so the returning
    // data is pushed exactly once; inflight_last tags that beat as final.
    // busy and done are registered alongside the state transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= last_issue;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= READING;
                        rd_ptr <= '0;
                        busy   <= 1'b1;
                    end
                end
                READING: begin
                    if (issue) begin
                        if (last_issue) begin
                            rd_ptr <= '0;
                            state  <= DRAIN;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy. Pointers are FW bits wide so they wrap
    // modulo FIFO_DEPTH on their own. Simultaneous push and pop leave the
    // count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx     <= '0;
            rd_idx     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage needs no reset: the pointers decide what is visible, and
    // m_last is gated by m_valid so stale sideband bits never leak out.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_idx] <= push_data;
            fifo_last[wr_idx] <= inflight_last;
        end
    end

endmodule

// File: tb/tb_poly_stream_out.sv
// tb_poly_stream_out
//
// Bench for poly_stream_out with N=64, K=16, FIFO_DEPTH=4. A behavioural
// BRAM pair holds the coefficients in the bank/address layout; a stream
// scoreboard checks every cycle that reads respect the credit limit, beats
// come out in index order with the right contents and m_last, and done
// follows the final handshake. Directed scenarios pin cycle-exact timing.

module tb_poly_stream_out;

    localparam int N          = 64;
    localparam int K          = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int NB         = N / 4;
    localparam int AW         = $clog2(NB) + 1;
    localparam int DW         = 4 * K;
    localparam int LOGN       = 4096;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 m_ready;
    logic [3:0]           bram_en;
    logic [3:0]           bram_we;
    logic [3:0][AW-1:0]   bram_addr_a;
    logic [3:0][AW-1:0]   bram_addr_b;
    logic [3:0][K-1:0]    bram_di_a;
    logic [3:0][K-1:0]    bram_di_b;
    logic [3:0][K-1:0]    bram_do_a;
    logic [3:0][K-1:0]    bram_do_b;
    logic [DW-1:0]        m_data;
    logic                 m_valid;
    logic                 m_last;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    poly_stream_out #(
        .N          (N),
        .K          (K),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_addr_a (bram_addr_a),
        .bram_addr_b (bram_addr_b),
        .bram_di_a   (bram_di_a),
        .bram_di_b   (bram_di_b),
        .bram_do_a   (bram_do_a),
        .bram_do_b   (bram_do_b),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done)
    );

    // Source memories: coefficient i in bank i%2 at address i/2
    logic [K-1:0] coef  [N];
    logic [K-1:0] bank0 [N/2];
    logic [K-1:0] bank1 [N/2];
    logic [K-1:0] do_a0 = '0;
    logic [K-1:0] do_b0 = '0;
    logic [K-1:0] do_a1 = '0;
    logic [K-1:0] do_b1 = '0;

    assign bram_do_a = {{(2*K){1'b0}}, do_a1, do_a0};
    assign bram_do_b = {{(2*K){1'b0}}, do_b1, do_b0};

    // One-cycle read latency BRAM model
    always @(posedge clk) begin
        if (bram_en[0]) begin
            do_a0 <= bank0[bram_addr_a[0]];
            do_b0 <= bank0[bram_addr_b[0]];
        end
        if (bram_en[1]) begin
            do_a1 <= bank1[bram_addr_a[1]];
            do_b1 <= bank1[bram_addr_b[1]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rdy, input logic rst);
        start   = st;
        m_ready = rdy;
        reset   = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic load_coefs(input bit rnd);
        for (int i = 0; i < N; i++) begin
            coef[i] = rnd ? K'($urandom) : K'(i);
            if (i % 2 == 0) bank0[i/2] = coef[i];
            else            bank1[i/2] = coef[i];
        end
    endtask

    function automatic logic [DW-1:0] exp_beat(input int b);
        return {coef[4*b+3], coef[4*b+2], coef[4*b+1], coef[4*b]};
    endfunction

    // Scoreboard state: reads issued and beats accepted in the current drain.
    // Their difference is everything occupying or reserving a FIFO slot.
    int issued       = 0;
    int popped       = 0;
    int done_count   = 0;
    int beats_total  = 0;
    bit drain_open   = 0;
    bit prev_stall   = 0;
    bit prev_reset   = 1;
    bit last_hs_prev = 0;

    bit            log_valid [LOGN];
    bit            log_last  [LOGN];
    bit            log_done  [LOGN];
    bit            log_busy  [LOGN];
    bit            log_en    [LOGN];
    logic [DW-1:0] log_data  [LOGN];

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_valid[cyc] = m_valid;
            log_last[cyc]  = m_last;
            log_done[cyc]  = done;
            log_busy[cyc]  = busy;
            log_en[cyc]    = bram_en[0];
            log_data[cyc]  = m_data;
        end

        checkOutput("we_zero", DW'(bram_we), DW'(0));
        checkOutput("bank23_idle", DW'({bram_en[3:2], bram_addr_a[3], bram_addr_a[2],
                                        bram_addr_b[3], bram_addr_b[2]}), DW'(0));
        checkOutput("di_zero", DW'(|{bram_di_a, bram_di_b}), DW'(0));
        checkOutput("en_pair", DW'(bram_en[1]), DW'(bram_en[0]));

        if (bram_en[0]) begin
            checkOutput("credit", DW'(issued - popped < FIFO_DEPTH), DW'(1));
            checkOutput("read_count", DW'(issued < NB), DW'(1));
            checkOutput("addr_a0", DW'(bram_addr_a[0]), DW'(2 * issued));
            checkOutput("addr_a1", DW'(bram_addr_a[1]), DW'(2 * issued));
            checkOutput("addr_b0", DW'(bram_addr_b[0]), DW'(2 * issued + 1));
            checkOutput("addr_b1", DW'(bram_addr_b[1]), DW'(2 * issued + 1));
            issued++;
            drain_open = 1;
        end else if (!reset && drain_open && issued < NB && issued - popped < FIFO_DEPTH) begin
            checkOutput("issue_missing", DW'(bram_en[0]), DW'(1));
        end

        if (prev_stall && !prev_reset)
            checkOutput("valid_held", DW'(m_valid), DW'(1));

        if (m_valid) begin
            checkOutput("valid_in_drain", DW'(drain_open), DW'(1));
            checkOutput("beat_data", m_data, exp_beat(popped));
            checkOutput("beat_last", DW'(m_last), DW'(popped == NB - 1));
        end else begin
            checkOutput("last_idle", DW'(m_last), DW'(0));
        end

        checkOutput("done_pulse", DW'(done), DW'(last_hs_prev));
        if (done) done_count++;

        last_hs_prev = 0;
        if (m_valid && m_ready) begin
            beats_total++;
            if (popped == NB - 1) begin
                last_hs_prev = 1;
                issued       = 0;
                popped       = 0;
                drain_open   = 0;
            end else begin
                popped++;
            end
        end

        prev_stall = m_valid && !m_ready;
        prev_reset = reset;
        if (reset) begin
            issued       = 0;
            popped       = 0;
            drain_open   = 0;
            last_hs_prev = 0;
        end
    end

    // Runs until one more done pulse has been seen, bounded by budget cycles
    task automatic waitDone(input bit rnd_ready, input int budget);
        int d0;
        d0 = done_count;
        for (int i = 0; i < budget && done_count == d0; i++)
            applyStimulus(1'b0, rnd_ready ? 1'($urandom_range(1)) : 1'b1, 1'b0);
        checkOutput("drain_finished", DW'(done_count - d0), DW'(1));
    endtask

    initial begin
        int s;
        int b0;
        int d0;
        int d;

        load_coefs(0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);

        // Reset state
        checkOutput("rst_valid", DW'(m_valid), DW'(0));
        checkOutput("rst_last", DW'(m_last), DW'(0));
        checkOutput("rst_busy", DW'(busy), DW'(0));
        checkOutput("rst_done", DW'(done), DW'(0));
        checkOutput("rst_en", DW'(bram_en), DW'(0));
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Full rate, coeff i = i
        $display("[TB] full-rate drain");
        s = cyc;
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (24) applyStimulus(1'b0, 1'b1, 1'b0);
        for (int c = 0; c <= 22; c++) begin
            checkOutput("fr_valid", DW'(log_valid[s+c]), DW'(c >= 3 && c <= 18));
            checkOutput("fr_last", DW'(log_last[s+c]), DW'(c == 18));
            checkOutput("fr_done", DW'(log_done[s+c]), DW'(c == 19));
            checkOutput("fr_busy", DW'(log_busy[s+c]), DW'(c >= 1 && c <= 18));
            checkOutput("fr_en", DW'(log_en[s+c]), DW'(c >= 1 && c <= 16));
        end
        checkOutput("fr_beat0", log_data[s+3], 64'h0003_0002_0001_0000);
        checkOutput("fr_beat15", log_data[s+18], 64'h003f_003e_003d_003c);

        // Stall: consumer not ready for cycles 0..20
        $display("[TB] stalled drain");
        b0 = beats_total;
        s  = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            checkOutput("st_en", DW'(log_en[s+c]), DW'(c <= 4));
            checkOutput("st_valid", DW'(log_valid[s+c]), DW'(c >= 3));
            if (c >= 3)
                checkOutput("st_beat0", log_data[s+c], 64'h0003_0002_0001_0000);
        end
        waitDone(1'b0, 200);
        checkOutput("st_beats", DW'(beats_total - b0), DW'(NB));

        // Random backpressure with random coefficients
        $display("[TB] random backpressure");
        for (int r = 0; r < 3; r++) begin
            load_coefs(1);
            b0 = beats_total;
            applyStimulus(1'b1, 1'($urandom_range(1)), 1'b0);
            waitDone(1'b1, 2000);
            checkOutput("rnd_beats", DW'(beats_total - b0), DW'(NB));
        end

        // Reset in cycle 5 of a drain
        $display("[TB] mid-drain reset");
        load_coefs(1);
        s = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mr_valid", DW'(m_valid), DW'(0));
        checkOutput("mr_busy", DW'(busy), DW'(0));
        checkOutput("mr_en", DW'(bram_en), DW'(0));
        checkOutput("mr_done", DW'(done), DW'(0));
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
        for (int c = 6; c <= 10; c++)
            checkOutput("mr_quiet", DW'(log_valid[s+c] | log_en[s+c]), DW'(0));
        b0 = beats_total;
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitDone(1'b0, 200);
        checkOutput("mr_beats", DW'(beats_total - b0), DW'(NB));

        // start pulses during READING/DRAIN are ignored
        $display("[TB] start pulses while busy");
        load_coefs(1);
        b0 = beats_total;
        d0 = done_count;
        applyStimulus(1'b1, 1'($urandom_range(1)), 1'b0);
        for (int i = 0; i < 2000 && done_count == d0; i++)
            applyStimulus(1'(i % 3 == 0), 1'($urandom_range(1)), 1'b0);
        s = cyc;
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("sp_dones", DW'(done_count - d0), DW'(1));
        checkOutput("sp_beats", DW'(beats_total - b0), DW'(NB));
        for (int c = 0; c < 10; c++)
            checkOutput("sp_idle", DW'(log_busy[s+c]), DW'(0));

        // start held high through DONE restarts from IDLE
        $display("[TB] start held through done");
        b0 = beats_total;
        d0 = done_count;
        for (int i = 0; i < 200 && done_count == d0; i++)
            applyStimulus(1'b1, 1'b1, 1'b0);
        d = cyc - 1;
        checkOutput("held_first_done", DW'(done_count - d0), DW'(1));
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitDone(1'b0, 200);
        checkOutput("held_idle_busy", DW'(log_busy[d+1]), DW'(0));
        checkOutput("held_idle_en", DW'(log_en[d+1]), DW'(0));
        checkOutput("held_restart_busy", DW'(log_busy[d+2]), DW'(1));
        checkOutput("held_restart_en", DW'(log_en[d+2]), DW'(1));
        checkOutput("held_beats", DW'(beats_total - b0), DW'(2 * NB));

        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/poly_stream_out.md
# poly_stream_out

Drain stage for the polynomial-ops datapath. After an element-wise op (add/sub/mul) writes its result polynomial into a dual-port BRAM pair, this block reads it back four coefficients per read and emits them on a valid/ready stream toward the host/DMA side. It absorbs stream backpressure with a small credit-tracked output FIFO. BRAM accesses are never stalled mid-flight.

## Interface
- N, `N: coefficients per polynomial, multiple of 4.
- K, `K: coefficient width in bits.
- FIFO_DEPTH, 4: output FIFO entries. Power of two, ≥4.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin draining one polynomial; sampled only in IDLE.
- bram  DPBRAMInterface  —  source BRAMs; this block drives en/we/addr_a/addr_b/di_a/di_b for banks 0–3 and reads do_a/do_b.
- m_data  out  4K  beat b: bits [K-1:0]=coeff 4b, [2K-1:K]=4b+1, [3K-1:2K]=4b+2, [4K-1:3K]=4b+3.
- m_valid  out  1  beat available.
- m_ready  in  1  consumer accepts beat when m_valid & m_ready.
- m_last  out  1  high on beat N/4-1.
- busy  out  1  high in READING or DRAIN.
- done  out  1  one-cycle pulse in DONE.

## Operation
- Memory layout: coeff i lives in bank i%2 at address i/2. Beat b reads bank0 addr_a=2b (4b), bank1 addr_a=2b (4b+1), bank0 addr_b=2b+1 (4b+2), bank1 addr_b=2b+1 (4b+3).
- BRAM read latency is one cycle. Data on do_* in the cycle after en is asserted.
- Banks 2,3: en=0, addr=0. All banks: we=0, di=0.
- FSM: IDLE, READING, DRAIN, DONE.
  - IDLE -> READING on start.
  - READING -> DRAIN in the cycle after the N/4-th read is issued.
  - DRAIN -> DONE on the handshake of the m_last beat.
  - DONE -> IDLE unconditionally.
- Read issue: in READING, assert en for banks 0,1 with rd_ptr's addresses iff (fifo_count + inflight) < FIFO_DEPTH. Increment rd_ptr (0..N/4-1) on issue.
- inflight is a 1-bit register: the issue of the previous cycle. Returned data is pushed into the FIFO the cycle it appears. It always has a free slot by the credit rule.
- m_last is carried as a FIFO sideband bit, set when the pushed beat index = N/4-1.
- Stream rules:
  - m_data/m_last are held stable while m_valid & !m_ready.
  - m_valid never drops without a handshake.
  - Beats are emitted strictly in index order, each exactly once.
- start outside IDLE is ignored. If start is held high through DONE, a new drain begins from IDLE on the following cycle.
- Reset values: state IDLE, rd_ptr 0, inflight 0, FIFO empty, m_valid 0, m_last 0, busy 0, done 0, all bram en/we 0.
- Reset mid-operation: flush the FIFO and discard any in-flight read. No beat emerges after reset.

## Timing
- Cycle 0: start high in IDLE.
- Cycle 1: READING, first en issued (beat 0).
- Cycle 2: do_* valid, FIFO push.
- Cycle 3: m_valid=1, beat 0 presented. First-beat latency from start is 3 cycles.
- Throughput: with m_ready constantly high, one beat per cycle with no bubbles (steady state: count 1, inflight 1 < 4).
- Handshake of the m_last beat in cycle t: done=1 and state DONE in t+1, IDLE in t+2, busy low from t+1.
- FIFO full (count + inflight = FIFO_DEPTH): en low, rd_ptr holds. Issue resumes in the cycle after a pop makes room.
- Push and pop in the same cycle: count unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.

## Test plan
- Full rate, N=16, coeff i = i, m_ready=1, start at cycle 0 -> m_valid cycles 3–6.
  - Beats {3,2,1,0}, {7,6,5,4}, {11,10,9,8}, {15,14,13,12}.
  - m_last only in cycle 6, done only in cycle 7, busy cycles 1–6.
- Stall, m_ready low cycles 0–20 -> exactly 4 reads issued (cycles 1–4), then en low.
  - m_valid high from cycle 3 with beat 0 stable throughout.
  - After m_ready rises, all beats arrive in order with no duplicates.
- Random m_ready (50%), N=64, random coefficients -> 16 beats exactly, bit-exact in order.
  - m_last on beat 15 only.
  - At every cycle en is low whenever count + inflight = 4.
- Reset asserted for one cycle in cycle 5 of a drain -> next cycle: m_valid=0, busy=0, FIFO empty, all en=0.
  - A following start yields beat 0 first.
- start pulsed during READING/DRAIN -> ignored: one done, N/4 beats.
  - start held high through DONE -> second drain begins, READING in the cycle after IDLE.
- Throughout all tests: we=0 on all banks; en/addr of banks 2,3 = 0.
